// File: rtl/ioctl_loader_pkg.sv
// Shared types and helpers for the ioctl ROM loader: FSM state encoding,
// a constant-foldable log2 and the default fill byte for partial words.
package ioctl_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        FLUSH,
        DONE
    } state_t;

    localparam logic [7:0] DEFAULT_PAD = 8'hFF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ioctl_rom_loader_if.sv
// Bundles the ioctl download channel and the ROM write port of the loader.
// master: byte source / ROM side, slave: the loader itself.
interface ioctl_rom_loader_if #(
    parameter int DW = 16,
    parameter int AW = 13
);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          ioctl_wait;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_din;
    logic          rom_wr;
    logic          rom_ready;
    logic          cpu_hold;
    logic          load_done;
    logic          overflow;
    logic [AW:0]   word_count;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, rom_ready,
        input  ioctl_wait, rom_addr, rom_din, rom_wr, cpu_hold, load_done, overflow, word_count
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, rom_ready,
        output ioctl_wait, rom_addr, rom_din, rom_wr, cpu_hold, load_done, overflow, word_count
    );
endinterface

// File: rtl/byte_packer.sv
// Lane-masked word buffer. word_o shows the buffer with this cycle's lane
// write already merged and every unwritten lane replaced by PAD.
module byte_packer
    import ioctl_loader_pkg::*;
#(
    parameter int         DW  = 16,
    parameter int         LW  = 1,
    parameter logic [7:0] PAD = DEFAULT_PAD
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [LW-1:0] lane_i,
    input  logic [7:0]    byte_i,
    output logic          any_o,
    output logic [DW-1:0] word_o
);
    localparam int BYTES = DW / 8;

    logic [DW-1:0]    buf_q;
    logic [BYTES-1:0] mask_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q <= '0;
        end else if (clr_i) begin
            mask_q <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_i && lane_i == LW'(i)) mask_q[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BYTES; i++) begin
            if (wr_i && lane_i == LW'(i)) buf_q[8*i +: 8] <= byte_i;
        end
    end

    always_comb begin
        word_o = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (wr_i && lane_i == LW'(i)) word_o[8*i +: 8] = byte_i;
            else if (mask_q[i])           word_o[8*i +: 8] = buf_q[8*i +: 8];
            else                          word_o[8*i +: 8] = PAD;
        end
    end

    assign any_o = |mask_q;

endmodule

// File: rtl/ioctl_rom_loader.sv
// Packs the ioctl little-endian byte stream into DW-bit ROM words and writes
// them over a ready/valid port, stalling the source with ioctl_wait.
module ioctl_rom_loader
    import ioctl_loader_pkg::*;
#(
    parameter int         DW            = 16,
    parameter int         AW            = 13,
    parameter logic [7:0] INDEX         = 8'h00,
    parameter logic [7:0] PAD           = DEFAULT_PAD,
    parameter bit         HOLD_AT_RESET = 1'b1
) (
    input  logic                clk_sys,
    input  logic                reset,
    ioctl_rom_loader_if.slave   bus
);
    localparam int          BYTES   = DW / 8;
    localparam int          LB      = clog2(BYTES);
    localparam int          LW      = (LB == 0) ? 1 : LB;
    localparam logic [63:0] CAP     = 64'(BYTES) << AW;
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    state_t        state_q, state_d;
    logic          sel, sel_q;
    logic          skid_vld_q, skid_vld_d;
    logic [24:0]   skid_addr_q, skid_addr_d;
    logic [7:0]    skid_data_q, skid_data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          wr_q, wr_d, wait_q, wait_d, hold_q, hold_d;
    logic          done_q, done_d, ovf_q, ovf_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic          pk_clr, pk_wr, pk_any;
    logic [DW-1:0] pk_word;

    // The skid byte, when present, is always older than a live strobe.
    logic          wr_in, eff_vld, eff_oor, eff_last;
    logic [24:0]   eff_addr;
    logic [7:0]    eff_data;
    logic [LW-1:0] eff_lane;
    logic [AW-1:0] eff_waddr;

    assign sel       = bus.ioctl_download && (bus.ioctl_index == INDEX);
    assign wr_in     = bus.ioctl_wr && sel;
    assign eff_vld   = skid_vld_q || wr_in;
    assign eff_addr  = skid_vld_q ? skid_addr_q : bus.ioctl_addr;
    assign eff_data  = skid_vld_q ? skid_data_q : bus.ioctl_dout;
    assign eff_lane  = LW'(eff_addr & 25'(BYTES - 1));
    assign eff_waddr = AW'(eff_addr >> LB);
    assign eff_oor   = 64'(eff_addr) >= CAP;
    assign eff_last  = (eff_lane == LW'(BYTES - 1));

    byte_packer #(.DW(DW), .LW(LW), .PAD(PAD)) u_packer (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .clr_i  (pk_clr),
        .wr_i   (pk_wr),
        .lane_i (eff_lane),
        .byte_i (eff_data),
        .any_o  (pk_any),
        .word_o (pk_word)
    );

    always_comb begin
        state_d     = state_q;
        skid_vld_d  = skid_vld_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        addr_d      = addr_q;
        din_d       = din_q;
        wr_d        = wr_q;
        hold_d      = hold_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        pk_clr      = 1'b0;
        pk_wr       = 1'b0;

        if ((state_q == WRITE || state_q == FLUSH) && wr_in) begin
            if (skid_vld_q) begin
                ovf_d = 1'b1;
            end else begin
                skid_vld_d  = 1'b1;
                skid_addr_d = bus.ioctl_addr;
                skid_data_d = bus.ioctl_dout;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (sel && !sel_q) begin
                    state_d    = COLLECT;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    hold_d     = 1'b1;
                    skid_vld_d = 1'b0;
                    pk_clr     = 1'b1;
                end
            end
            COLLECT: begin
                if (eff_vld) begin
                    skid_vld_d = 1'b0;
                    if (wr_in && skid_vld_q) begin
                        skid_vld_d  = 1'b1;
                        skid_addr_d = bus.ioctl_addr;
                        skid_data_d = bus.ioctl_dout;
                    end
                    if (eff_oor) begin
                        ovf_d = 1'b1;
                    end else if (pk_any && eff_waddr != addr_q) begin
                        // Park the new-word byte while the old word is flushed.
                        state_d     = FLUSH;
                        skid_vld_d  = 1'b1;
                        skid_addr_d = eff_addr;
                        skid_data_d = eff_data;
                        if (wr_in && skid_vld_q) ovf_d = 1'b1;
                    end else begin
                        pk_wr  = 1'b1;
                        addr_d = eff_waddr;
                        if (eff_last) begin
                            state_d = WRITE;
                            wr_d    = 1'b1;
                            din_d   = pk_word;
                        end
                    end
                end else if (!sel) begin
                    state_d = pk_any ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                state_d = WRITE;
                wr_d    = 1'b1;
                din_d   = pk_word;
            end
            WRITE: begin
                if (bus.rom_ready) begin
                    wr_d    = 1'b0;
                    pk_clr  = 1'b1;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
                    state_d = (sel || skid_vld_d) ? COLLECT : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                hold_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        wait_d = (state_d == WRITE) || (state_d == FLUSH) ||
                 (state_q == WRITE && bus.rom_ready);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            wait_q      <= 1'b0;
            hold_q      <= HOLD_AT_RESET;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel;
            skid_vld_q  <= skid_vld_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            wait_q      <= wait_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.rom_addr   = addr_q;
    assign bus.rom_din    = din_q;
    assign bus.rom_wr     = wr_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_done  = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.word_count = cnt_q;

endmodule
